bram_arbiter: RTL and testbench

//  Shares one single-port block RAM (1-cycle registered read) between three requesters:
//  - the boot loader (UART program load),
//  - the core data port (load/store),
//  - the core instruction-fetch port.

---
 rtl/bram_arbiter_if.sv | 52 +++++
 rtl/bram_arbiter.sv | 90 +++++++++
 tb/tb_bram_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_if.sv
// Port bundle for bram_arbiter: loader, core data, core fetch and BRAM sides.
// The slave modport is the arbiter; the master modport is the environment.
interface bram_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_din;
  logic              ld_gnt;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_din;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              f_req;
  logic [ADDR_W-3:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  ld_req, ld_addr, ld_din,
    output ld_gnt,
    input  d_req, d_we, d_addr, d_din,
    output d_gnt, d_rvalid, d_rdata,
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    output ram_en, ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output ld_req, ld_addr, ld_din,
    input  ld_gnt,
    output d_req, d_we, d_addr, d_din,
    input  d_gnt, d_rvalid, d_rdata,
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between boot loader (BOOT phase) and the core's
// data/fetch ports (RUN phase); data outranks fetch unless fetch has starved.
module bram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int STARVE = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           boot_done,
  output logic           core_run,
  bram_arbiter_if.slave  bus
);

  localparam int                CNT_W    = $clog2(STARVE + 1);
  localparam logic [CNT_W-1:0]  STARVE_C = CNT_W'(STARVE);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt, wait_next;
  logic               fetch_first;

  assign fetch_first = (wait_cnt == STARVE_C);

  always_comb begin
    state_next = state;
    if (state == BOOT && boot_done) state_next = RUN;
  end

  // Grants: loader only in BOOT; in RUN a starved fetch outranks data.
  always_comb begin
    bus.ld_gnt = 1'b0;
    bus.d_gnt  = 1'b0;
    bus.f_gnt  = 1'b0;
    if (state == BOOT) begin
      bus.ld_gnt = bus.ld_req;
    end else if (fetch_first && bus.f_req) begin
      bus.f_gnt = 1'b1;
    end else if (bus.d_req) begin
      bus.d_gnt = 1'b1;
    end else if (bus.f_req) begin
      bus.f_gnt = 1'b1;
    end
  end

  always_comb begin
    bus.ram_en   = bus.ld_gnt | bus.d_gnt | bus.f_gnt;
    bus.ram_we   = bus.ld_gnt | (bus.d_gnt & bus.d_we);
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (bus.ld_gnt) begin
      bus.ram_addr = bus.ld_addr;
      bus.ram_din  = bus.ld_din;
    end else if (bus.d_gnt) begin
      bus.ram_addr = bus.d_addr;
      bus.ram_din  = bus.d_din;
    end else if (bus.f_gnt) begin
      bus.ram_addr = {2'b00, bus.f_addr};
    end
  end

  always_comb begin
    wait_next = '0;
    if (state == RUN && bus.f_req && !bus.f_gnt)
      wait_next = fetch_first ? wait_cnt : wait_cnt + 1'b1;
  end

  assign bus.d_rdata = bus.ram_dout;
  assign bus.f_rdata = bus.ram_dout;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= BOOT;
      core_run     <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.f_rvalid <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state        <= state_next;
      core_run     <= (state_next == RUN);
      bus.d_rvalid <= bus.d_gnt & ~bus.d_we;
      bus.f_rvalid <= bus.f_gnt;
      wait_cnt     <= wait_next;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: hand-computed vectors plus boot/reset sequences,
// with a behavioural 1-cycle-latency BRAM attached to the ram_* port.
module tb_bram_arbiter;

  localparam int ADDR_W = 10;
  localparam int STARVE = 4;

  logic clk;
  logic rstn;
  logic boot_done;
  logic core_run;

  bram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  bram_arbiter #(.ADDR_W(ADDR_W), .STARVE(STARVE)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .boot_done (boot_done),
    .core_run  (core_run),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_din;
    logic        f_req;
    logic [7:0]  f_addr;
    logic        e_dg;
    logic        e_fg;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic        e_drv;
    logic        e_frv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic dr, input logic dw, input logic [9:0] da,
                              input logic [31:0] dd, input logic fr, input logic [7:0] fa,
                              input logic edg, input logic efg, input logic ewe,
                              input logic [9:0] ea, input logic [31:0] ed,
                              input logic edrv, input logic efrv, input logic [31:0] erd);
    vec_t v;
    v.d_req = dr;  v.d_we = dw;  v.d_addr = da;  v.d_din = dd;
    v.f_req = fr;  v.f_addr = fa;
    v.e_dg = edg;  v.e_fg = efg; v.e_we = ewe;   v.e_addr = ea; v.e_din = ed;
    v.e_drv = edrv; v.e_frv = efrv; v.e_rd = erd;
    return v;
  endfunction

  localparam logic [31:0] M5   = 32'hA5A5_0005;
  localparam logic [31:0] M32  = 32'h0000_2020;
  localparam logic [31:0] MFF  = 32'hCAFE_F00D;
  localparam logic [31:0] MTOP = 32'h1234_5678;

  vec_t tv[$];

  task automatic loader(input logic req, input logic [9:0] a, input logic [31:0] d);
    bus.ld_req  = req;
    bus.ld_addr = a;
    bus.ld_din  = d;
  endtask

  initial begin
    // d read 5 / f read 32 contending; counter evolution noted per row
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       1,0,0,10'd5,0,        0,0,0));
    tv.push_back(mk(0,0,0,0,1,8'd32,           0,1,0,10'd32,0,       1,0,M5));
    tv.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,            0,1,M32));
    tv.push_back(mk(1,1,10'h3FF,MTOP,0,0,      1,0,1,10'h3FF,MTOP,   0,0,0));
    tv.push_back(mk(1,0,10'h3FF,0,0,0,         1,0,0,10'h3FF,0,      0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,            1,0,MTOP));
    // starvation: 4 data grants then one fetch, twice
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       1,0,0,10'd5,0,        0,0,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1,0,10'd5,0,1,8'd32,     1,0,0,10'd5,0,        1,0,M5));
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       0,1,0,10'd32,0,       1,0,M5));
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       1,0,0,10'd5,0,        0,1,M32));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1,0,10'd5,0,1,8'd32,     1,0,0,10'd5,0,        1,0,M5));
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       0,1,0,10'd32,0,       1,0,M5));
    tv.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,            0,1,M32));
    // fetch address zero-extension
    tv.push_back(mk(0,0,0,0,1,8'hFF,           0,1,0,10'h0FF,0,      0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,            0,1,MFF));
    // dropping f_req clears the counter: 3 waits, drop, then a full 4 again
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       1,0,0,10'd5,0,        0,0,0));
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       1,0,0,10'd5,0,        1,0,M5));
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       1,0,0,10'd5,0,        1,0,M5));
    tv.push_back(mk(1,0,10'd5,0,0,0,           1,0,0,10'd5,0,        1,0,M5));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1,0,10'd5,0,1,8'd32,     1,0,0,10'd5,0,        1,0,M5));
    tv.push_back(mk(1,0,10'd5,0,1,8'd32,       0,1,0,10'd32,0,       1,0,M5));
    tv.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,            0,1,M32));

    rstn = 1'b0; boot_done = 1'b0;
    loader(0, 0, 0);
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_din = '0;
    bus.f_req = 0; bus.f_addr = '0;
    @(negedge clk);
    step();
    chk("rst core_run", {31'd0, core_run}, 0);
    chk("rst d_rvalid", {31'd0, bus.d_rvalid}, 0);
    chk("rst f_rvalid", {31'd0, bus.f_rvalid}, 0);
    chk("rst ram_en",   {31'd0, bus.ram_en}, 0);
    chk("rst ram_addr", {22'd0, bus.ram_addr}, 0);
    chk("rst ram_din",  bus.ram_din, 0);

    // BOOT: loader wins even with fetch requesting
    rstn = 1'b1;
    loader(1, 10'h080, 32'hDEAD_BEEF);
    bus.f_req = 1; bus.f_addr = 8'd7; bus.d_req = 1;
    #1;
    chk("boot ld_gnt",   {31'd0, bus.ld_gnt}, 1);
    chk("boot f_gnt",    {31'd0, bus.f_gnt}, 0);
    chk("boot d_gnt",    {31'd0, bus.d_gnt}, 0);
    chk("boot ram_we",   {31'd0, bus.ram_we}, 1);
    chk("boot ram_addr", {22'd0, bus.ram_addr}, 32'h080);
    chk("boot ram_din",  bus.ram_din, 32'hDEAD_BEEF);
    chk("boot core_run", {31'd0, core_run}, 0);
    step();
    bus.f_req = 0; bus.d_req = 0;
    loader(1, 10'd5, M5);   step();
    loader(1, 10'd32, M32); step();
    loader(1, 10'h0FF, MFF);
    boot_done = 1'b1;
    #1;
    chk("boot_done ld_gnt", {31'd0, bus.ld_gnt}, 1);
    chk("boot_done core_run", {31'd0, core_run}, 0);
    step();
    boot_done = 1'b0;
    loader(0, 0, 0);
    #1;
    chk("run core_run", {31'd0, core_run}, 1);
    chk("run f_rvalid", {31'd0, bus.f_rvalid}, 0);

    loader(1, 10'h010, 32'h1111_1111);
    #1;
    chk("run ld_gnt", {31'd0, bus.ld_gnt}, 0);
    chk("run ld ram_en", {31'd0, bus.ram_en}, 0);
    step();
    loader(0, 0, 0);

    foreach (tv[i]) begin
      bus.d_req  = tv[i].d_req;
      bus.d_we   = tv[i].d_we;
      bus.d_addr = tv[i].d_addr;
      bus.d_din  = tv[i].d_din;
      bus.f_req  = tv[i].f_req;
      bus.f_addr = tv[i].f_addr;
      #1;
      chk($sformatf("v%0d ld_gnt", i),   {31'd0, bus.ld_gnt}, 0);
      chk($sformatf("v%0d d_gnt", i),    {31'd0, bus.d_gnt}, {31'd0, tv[i].e_dg});
      chk($sformatf("v%0d f_gnt", i),    {31'd0, bus.f_gnt}, {31'd0, tv[i].e_fg});
      chk($sformatf("v%0d ram_en", i),   {31'd0, bus.ram_en}, {31'd0, tv[i].e_dg | tv[i].e_fg});
      chk($sformatf("v%0d ram_we", i),   {31'd0, bus.ram_we}, {31'd0, tv[i].e_we});
      chk($sformatf("v%0d ram_addr", i), {22'd0, bus.ram_addr}, {22'd0, tv[i].e_addr});
      chk($sformatf("v%0d ram_din", i),  bus.ram_din, tv[i].e_din);
      chk($sformatf("v%0d d_rvalid", i), {31'd0, bus.d_rvalid}, {31'd0, tv[i].e_drv});
      chk($sformatf("v%0d f_rvalid", i), {31'd0, bus.f_rvalid}, {31'd0, tv[i].e_frv});
      if (tv[i].e_drv) chk($sformatf("v%0d d_rdata", i), bus.d_rdata, tv[i].e_rd);
      if (tv[i].e_frv) chk($sformatf("v%0d f_rdata", i), bus.f_rdata, tv[i].e_rd);
      step();
    end

    // reset asserted in the cycle of a granted read
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd5; bus.f_req = 0;
    rstn = 1'b0;
    #1;
    chk("rstmid d_gnt before", {31'd0, bus.d_gnt}, 1);
    step();
    chk("rstmid d_rvalid", {31'd0, bus.d_rvalid}, 0);
    chk("rstmid core_run", {31'd0, core_run}, 0);
    chk("rstmid d_gnt after", {31'd0, bus.d_gnt}, 0);
    bus.d_req = 0;
    loader(1, 10'd3, 32'h0000_0003);
    #1;
    chk("rstmid ld_gnt boot", {31'd0, bus.ld_gnt}, 1);
    rstn = 1'b1;
    step();
    loader(0, 0, 0);
    chk("rstmid d_rvalid2", {31'd0, bus.d_rvalid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
